aibndaux_detect_por_seq: RTL and testbench



---
 rtl/aibndaux_detect_por_seq.sv | 144 ++++++++++++++
 tb/tb_aibndaux_detect_por_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aibndaux_detect_por_seq.sv
// aibndaux_detect_por_seq
// Multi-channel aux die-detect filter and partner-POR sequencer for the AIB aux bank.
// Raw detects are synchronised and debounced. A WAIT/HOLD/READY machine then releases
// dn_por to the partner once every enabled channel has been stably present for POR_HOLD cycles.
module aibndaux_detect_por_seq #(
    parameter int NCH      = 2,
    parameter int DEB_CNT  = 16,
    parameter int POR_HOLD = 64
) (
    input  logic           osc_clk,
    input  logic           osc_rst,
    input  logic [NCH-1:0] crdet_raw,
    input  logic [NCH-1:0] ch_en,
    input  logic           por_in,
    input  logic           clr_err,
    output logic [NCH-1:0] crete_det,
    output logic [NCH-1:0] dn_por_out,
    output logic           link_ready,
    output logic           det_lost,
    output logic [1:0]     state_o
);

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam int HW = $clog2(POR_HOLD + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(POR_HOLD - 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_READY = 2'b10
    } state_t;

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    state_t         state_q;
    state_t         state_d;
    logic [HW-1:0]  hold_cnt_q;
    logic [HW-1:0]  hold_cnt_d;
    logic           set_lost;
    logic           all_det;
    logic           any_en;

    // Two-flop synchroniser bringing the pad detects into the osc_clk domain
    always_ff @(posedge osc_clk) begin
        if (osc_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= crdet_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          det_q;

        // A new detect level is accepted only after DEB_CNT consecutive differing samples
        always_ff @(posedge osc_clk) begin
            if (osc_rst) begin
                cnt   <= '0;
                det_q <= 1'b0;
            end else if (sync2[i] == det_q) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                det_q <= sync2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end

        assign crete_det[i] = det_q;
    end

    // Disabled channels count as present so they never block link-up
    assign all_det = &(crete_det | ~ch_en);
    assign any_en  = |ch_en;

    // Next-state logic: a POR request or any loss of presence always falls back to WAIT
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        set_lost   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (all_det && any_en && !por_in) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (por_in || !all_det) begin
                    state_d = ST_WAIT;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_READY;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_READY: begin
                if (por_in || !any_en) begin
                    state_d = ST_WAIT;
                end else if (!all_det) begin
                    state_d  = ST_WAIT;
                    set_lost = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // State register with outputs registered from the next state so they move together
    always_ff @(posedge osc_clk) begin
        if (osc_rst) begin
            state_q    <= ST_WAIT;
            hold_cnt_q <= '0;
            dn_por_out <= '1;
            link_ready <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            dn_por_out <= {NCH{state_d != ST_READY}} | ~ch_en;
            link_ready <= (state_d == ST_READY);
        end
    end

    // Sticky loss flag; a new loss wins over a simultaneous clear
    always_ff @(posedge osc_clk) begin
        if (osc_rst) begin
            det_lost <= 1'b0;
        end else if (set_lost) begin
            det_lost <= 1'b1;
        end else if (clr_err) begin
            det_lost <= 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_aibndaux_detect_por_seq.sv
// tb_aibndaux_detect_por_seq
// Directed link-up/loss/POR scenarios followed by randomized stimulus, with every
// cycle compared against a behavioural model of the detect filter and link sequencer.
module tb_aibndaux_detect_por_seq;

    localparam int NCH      = 4;
    localparam int DEB_CNT  = 4;
    localparam int POR_HOLD = 8;

    logic           osc_clk;
    logic           osc_rst;
    logic [NCH-1:0] crdet_raw;
    logic [NCH-1:0] ch_en;
    logic           por_in;
    logic           clr_err;
    logic [NCH-1:0] crete_det;
    logic [NCH-1:0] dn_por_out;
    logic           link_ready;
    logic           det_lost;
    logic [1:0]     state_o;

    int assert_count = 0;
    int fail_count   = 0;

    aibndaux_detect_por_seq #(
        .NCH      (NCH),
        .DEB_CNT  (DEB_CNT),
        .POR_HOLD (POR_HOLD)
    ) dut (
        .osc_clk    (osc_clk),
        .osc_rst    (osc_rst),
        .crdet_raw  (crdet_raw),
        .ch_en      (ch_en),
        .por_in     (por_in),
        .clr_err    (clr_err),
        .crete_det  (crete_det),
        .dn_por_out (dn_por_out),
        .link_ready (link_ready),
        .det_lost   (det_lost),
        .state_o    (state_o)
    );

    // Free-running aux oscillator
    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    // Reference model: mode 0=WAIT, 1=HOLD, 2=READY; hold_age counts edges spent in HOLD
    bit [NCH-1:0] m_s1, m_s2, m_det, m_dn, n_det;
    int           m_run [NCH];
    int           m_mode, n_mode, m_age;
    bit           m_lr, m_lost, m_valid;
    bit           all_present, some_enabled, lose;

    // Advance the model on each edge from the inputs presented before that edge
    always @(posedge osc_clk) begin
        if (osc_rst) begin
            m_s1 = '0; m_s2 = '0; m_det = '0;
            for (int i = 0; i < NCH; i++) m_run[i] = 0;
            m_mode = 0; m_age = 0; m_dn = '1; m_lr = 1'b0; m_lost = 1'b0;
            m_valid = 1'b1;
        end else begin
            all_present  = ((m_det | ~ch_en) == '1);
            some_enabled = (ch_en != '0);
            lose         = 1'b0;
            n_mode       = m_mode;
            if (m_mode == 0) begin
                if (all_present && some_enabled && !por_in) begin
                    n_mode = 1;
                    m_age  = 0;
                end
            end else if (m_mode == 1) begin
                if (por_in || !all_present) begin
                    n_mode = 0;
                end else begin
                    m_age = m_age + 1;
                    if (m_age >= POR_HOLD) n_mode = 2;
                end
            end else begin
                if (por_in || !some_enabled) begin
                    n_mode = 0;
                end else if (!all_present) begin
                    n_mode = 0;
                    lose   = 1'b1;
                end
            end
            if (lose) m_lost = 1'b1;
            else if (clr_err) m_lost = 1'b0;
            m_dn   = ~ch_en | ((n_mode == 2) ? '0 : '1);
            m_lr   = (n_mode == 2);
            m_mode = n_mode;
            n_det  = m_det;
            for (int i = 0; i < NCH; i++) begin
                if (m_s2[i] != m_det[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB_CNT) begin
                        n_det[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_det = n_det;
            m_s2  = m_s1;
            m_s1  = crdet_raw;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge osc_clk) begin
        if (m_valid) begin
            checkOutput("model crete_det", 32'(crete_det), 32'(m_det));
            checkOutput("model dn_por_out", 32'(dn_por_out), 32'(m_dn));
            checkOutput("model link_ready", 32'(link_ready), 32'(m_lr));
            checkOutput("model det_lost", 32'(det_lost), 32'(m_lost));
            checkOutput("model state_o", 32'(state_o), 32'(m_mode));
        end
    end

    task automatic applyStimulus(input logic rst, input logic [NCH-1:0] en, input logic [NCH-1:0] raw,
                                 input logic por, input logic clr);
        osc_rst   = rst;
        ch_en     = en;
        crdet_raw = raw;
        por_in    = por;
        clr_err   = clr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge osc_clk);
        #1;
    endtask

    // Bounded run time so a stuck simulation still terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    int rate;

    // Directed scenarios with hand-computed expectations, then randomized traffic
    initial begin
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(3);
        // Last reset edge is edge 0; inputs change just after it
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
        checkOutput("reset state_o", 32'(state_o), 32'h0);
        checkOutput("reset dn_por_out", 32'(dn_por_out), 32'hF);
        checkOutput("reset link_ready", 32'(link_ready), 32'h0);
        checkOutput("reset det_lost", 32'(det_lost), 32'h0);
        checkOutput("reset crete_det", 32'(crete_det), 32'h0);

        tick(5);
        checkOutput("linkup det edge5", 32'(crete_det), 32'h0);
        tick(1);
        checkOutput("linkup det edge6", 32'(crete_det), 32'hF);
        checkOutput("linkup state edge6", 32'(state_o), 32'h0);
        tick(1);
        checkOutput("linkup state edge7", 32'(state_o), 32'h1);
        tick(7);
        checkOutput("linkup state edge14", 32'(state_o), 32'h1);
        checkOutput("linkup ready edge14", 32'(link_ready), 32'h0);
        tick(1);
        checkOutput("linkup state edge15", 32'(state_o), 32'h2);
        checkOutput("linkup ready edge15", 32'(link_ready), 32'h1);
        checkOutput("linkup dn_por edge15", 32'(dn_por_out), 32'h0);

        crdet_raw = 4'b1011;
        tick(3);
        crdet_raw = 4'b1111;
        tick(10);
        checkOutput("glitch det", 32'(crete_det), 32'hF);
        checkOutput("glitch state", 32'(state_o), 32'h2);
        checkOutput("glitch det_lost", 32'(det_lost), 32'h0);

        crdet_raw = 4'b1011;
        tick(5);
        checkOutput("loss det +5", 32'(crete_det), 32'hF);
        tick(1);
        checkOutput("loss det +6", 32'(crete_det), 32'hB);
        checkOutput("loss state +6", 32'(state_o), 32'h2);
        tick(1);
        checkOutput("loss state +7", 32'(state_o), 32'h0);
        checkOutput("loss dn_por +7", 32'(dn_por_out), 32'hF);
        checkOutput("loss det_lost +7", 32'(det_lost), 32'h1);
        checkOutput("loss ready +7", 32'(link_ready), 32'h0);
        tick(1);
        crdet_raw = 4'b1111;
        clr_err   = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("clr_err det_lost", 32'(det_lost), 32'h0);

        ch_en     = 4'b0101;
        crdet_raw = 4'b0101;
        tick(20);
        checkOutput("mask state", 32'(state_o), 32'h2);
        checkOutput("mask dn_por", 32'(dn_por_out), 32'hA);
        for (int i = 0; i < 12; i++) begin
            crdet_raw[1] = ~crdet_raw[1];
            tick(2);
        end
        checkOutput("mask toggle state", 32'(state_o), 32'h2);
        checkOutput("mask toggle dn_por", 32'(dn_por_out), 32'hA);
        checkOutput("mask toggle det_lost", 32'(det_lost), 32'h0);

        por_in = 1'b1;
        tick(2);
        checkOutput("por held state", 32'(state_o), 32'h0);
        por_in = 1'b0;
        tick(1);
        checkOutput("por release state", 32'(state_o), 32'h1);
        tick(5);
        checkOutput("por hold5 state", 32'(state_o), 32'h1);
        por_in = 1'b1;
        tick(1);
        por_in = 1'b0;
        checkOutput("por pulse state", 32'(state_o), 32'h0);
        tick(1);
        checkOutput("por reentry state", 32'(state_o), 32'h1);
        tick(7);
        checkOutput("por reentry+7 state", 32'(state_o), 32'h1);
        tick(1);
        checkOutput("por reentry+8 state", 32'(state_o), 32'h2);

        ch_en = 4'b0000;
        tick(1);
        checkOutput("empty state", 32'(state_o), 32'h0);
        checkOutput("empty dn_por", 32'(dn_por_out), 32'hF);
        checkOutput("empty det_lost", 32'(det_lost), 32'h0);
        tick(5);
        checkOutput("empty held state", 32'(state_o), 32'h0);
        checkOutput("empty held dn_por", 32'(dn_por_out), 32'hF);

        ch_en = 4'b0101;
        tick(1);
        checkOutput("midhold state", 32'(state_o), 32'h1);
        tick(3);
        osc_rst = 1'b1;
        tick(1);
        checkOutput("midreset state", 32'(state_o), 32'h0);
        checkOutput("midreset dn_por", 32'(dn_por_out), 32'hF);
        checkOutput("midreset ready", 32'(link_ready), 32'h0);
        checkOutput("midreset det_lost", 32'(det_lost), 32'h0);
        checkOutput("midreset crete_det", 32'(crete_det), 32'h0);

        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
        tick(15);
        checkOutput("relink state", 32'(state_o), 32'h2);
        crdet_raw = 4'b1110;
        tick(6);
        checkOutput("simul det", 32'(crete_det), 32'hE);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("simul det_lost", 32'(det_lost), 32'h1);
        checkOutput("simul state", 32'(state_o), 32'h0);
        tick(1);
        checkOutput("simul det_lost held", 32'(det_lost), 32'h1);
        crdet_raw = 4'b1111;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rate = ((cyc / 150) % 2 == 1) ? 40 : 500;
            osc_rst = ($urandom_range(0, 799) == 0);
            por_in  = ($urandom_range(0, 199) == 0);
            clr_err = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) ch_en = 4'($urandom_range(0, 15));
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, rate - 1) == 0) crdet_raw[c] = ~crdet_raw[c];
                else if (rate > 100 && !crdet_raw[c] && $urandom_range(0, 7) == 0) crdet_raw[c] = 1'b1;
            end
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
